// File: rtl/decode_pkg.sv
// decode_pkg: shared decode definitions for decode_regfile_stage.
//   - MIPS opcode / funct constants for the supported subset
//   - aluop_e: 2-bit main-decoder to ALU-decoder handoff
//   - ALU control line encodings
//   - ctrl_t: control bits carried through ID/EX
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,  // memory / addi address add
    ALUOP_SUB   = 2'b01,  // beq compare
    ALUOP_FUNCT = 2'b10   // R-type, look at funct
  } aluop_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    aluop_e aluop;
    logic   mem_r;
    logic   mem_w;
    logic   reg_w;
    logic   mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NUM_REGS x DATA_W register file, two combinational read
// ports, one synchronous write port. Register 0 always reads zero and
// ignores writes. Synchronous active-high reset clears every register.
// Optional macro DECODE_BYPASS_EN: a same-cycle write to the index being
// read is forwarded to the read port (write-through).
// Ports: clk, reset, wb_en/wb_addr/wb_data (write), ra1/ra2 -> rd1/rd2 (read).
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            wr;

  assign wr = wb_en && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (reset)   regs <= '0;
    else if (wr) regs[wb_addr] <= wb_data;
  end

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : regs[ra2];
`ifdef DECODE_BYPASS_EN
    // wr already excludes index 0, so the zero register stays zero
    if (wr && (wb_addr == ra1)) rd1 = wb_data;
    if (wr && (wb_addr == ra2)) rd2 = wb_data;
`endif
  end

endmodule

// File: rtl/decode_regfile_stage.sv
// decode_regfile_stage: MIPS decode + register read, registered into an
// ID/EX stage (1-cycle latency) with valid, stall and flush.
// Optional macro DECODE_BYPASS_EN: write-through forwarding in the regfile.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid, instr     instruction from IF/ID
//   stall, flush        hold / kill ID/EX; in_ready = !stall
//   wb_en/addr/data     write-back port
//   ex_*                ID/EX outputs toward the ALU
// Supports NUM_REGS up to 32 (register fields are 5 bits in the encoding).
module decode_regfile_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_operand1,
  output logic [DATA_W-1:0] ex_operand2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [ADDR_W-1:0] ex_dest,
  output logic              ex_mem_r,
  output logic              ex_mem_w,
  output logic              ex_reg_w,
  output logic              ex_mem_to_reg,
  output logic [3:0]        ex_alu_ctrl,
  output logic              ex_illegal
);

  logic [5:0]        opcode, funct;
  logic [4:0]        rs5, rt5, rd5;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic              unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign rs5          = instr[25:21];
  assign rt5          = instr[20:16];
  assign rd5          = instr[15:11];
  assign rs           = rs5[ADDR_W-1:0];
  assign rt           = rt5[ADDR_W-1:0];
  assign rd           = rd5[ADDR_W-1:0];
  assign unused_shamt = ^instr[10:6];
  assign in_ready     = !stall;

  regfile_2r1w #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk, .reset, .wb_en, .wb_addr, .wb_data,
    .ra1(rs), .ra2(rt), .rd1, .rd2
  );

  always_comb begin
    if (IMM_SEXT) imm = DATA_W'(signed'(instr[15:0]));
    else          imm = DATA_W'(instr[15:0]);
  end

  // ---- decode ----
  ctrl_t       dec;
  logic [3:0]  dec_alu;
  logic        dec_ill;
  logic        op_ill;

  always_comb begin
    dec    = '0;
    op_ill = 1'b0;
    case (opcode)
      OP_RTYPE: begin dec.aluop = ALUOP_FUNCT; dec.reg_w = 1'b1; end
      OP_LW:    begin dec.mem_r = 1'b1; dec.reg_w = 1'b1; dec.mem_to_reg = 1'b1; end
      OP_SW:    dec.mem_w = 1'b1;
      OP_ADDI:  dec.reg_w = 1'b1;
      OP_BEQ:   dec.aluop = ALUOP_SUB;
      default:  op_ill = 1'b1;
    endcase

    dec_ill = op_ill;
    case (dec.aluop)
      ALUOP_ADD: dec_alu = ALU_ADD;
      ALUOP_SUB: dec_alu = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  dec_alu = ALU_ADD;
          FN_SUB:  dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_SLT:  dec_alu = ALU_SLT;
          default: begin
            // unknown funct must never retire a register write
            dec_alu   = ALU_AND;
            dec_ill   = 1'b1;
            dec.reg_w = 1'b0;
          end
        endcase
      end
      default: dec_alu = ALU_AND;
    endcase
    // unknown opcode: every control line low
    if (op_ill) dec_alu = ALU_AND;
  end

  // ---- ID/EX register ----
  ctrl_t ex_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_ctrl       <= '0;
      ex_alu_ctrl   <= '0;
      ex_illegal    <= 1'b0;
      ex_operand1   <= '0;
      ex_operand2   <= '0;
      ex_store_data <= '0;
      ex_dest       <= '0;
    end else if (flush) begin
      // data fields left as-is; only control state matters for a bubble
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_alu_ctrl <= '0;
      ex_illegal  <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= in_valid;
      ex_ctrl       <= in_valid ? dec : '0;
      ex_alu_ctrl   <= in_valid ? dec_alu : '0;
      ex_illegal    <= in_valid && dec_ill;
      ex_operand1   <= rd1;
      ex_operand2   <= (dec.aluop == ALUOP_ADD) ? imm : rd2;
      ex_store_data <= rd2;
      ex_dest       <= (opcode == OP_RTYPE) ? rd : rt;
    end
  end

  assign ex_mem_r      = ex_ctrl.mem_r;
  assign ex_mem_w      = ex_ctrl.mem_w;
  assign ex_reg_w      = ex_ctrl.reg_w;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_decode_regfile_stage.sv
module tb_decode_regfile_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, wb_en;
  logic [31:0] instr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        in_ready, ex_valid;
  logic [31:0] ex_operand1, ex_operand2, ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_mem_r, ex_mem_w, ex_reg_w, ex_mem_to_reg, ex_illegal;
  logic [3:0]  ex_alu_ctrl;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decode_regfile_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .stall(stall), .flush(flush), .in_ready(in_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_reg_w(ex_reg_w),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_ctrl(ex_alu_ctrl), .ex_illegal(ex_illegal)
  );

  typedef struct {
    string       name;
    bit          v;
    logic [31:0] op1, op2, sd;
    logic [4:0]  dest;
    bit          mr, mw, rw, m2r, ill;
    logic [3:0]  alu;
    bit          cd;   // compare data fields
    bit          ca;   // compare alu control
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(string name, bit v, logic [31:0] op1, logic [31:0] op2,
                              logic [31:0] sd, logic [4:0] dest, bit mr, bit mw, bit rw,
                              bit m2r, logic [3:0] alu, bit ill, bit cd, bit ca);
    exp_t e;
    e.name = name; e.v = v; e.op1 = op1; e.op2 = op2; e.sd = sd; e.dest = dest;
    e.mr = mr; e.mw = mw; e.rw = rw; e.m2r = m2r; e.alu = alu; e.ill = ill;
    e.cd = cd; e.ca = ca;
    return e;
  endfunction

  // bubble: valid low, controls low, data ignored
  function automatic exp_t bub(string name);
    return mk(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: one expectation per cycle, compared on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".valid"}, 32'(ex_valid), 32'(e.v));
      chk({e.name, ".mem_r"}, 32'(ex_mem_r), 32'(e.mr));
      chk({e.name, ".mem_w"}, 32'(ex_mem_w), 32'(e.mw));
      chk({e.name, ".reg_w"}, 32'(ex_reg_w), 32'(e.rw));
      chk({e.name, ".m2r"},   32'(ex_mem_to_reg), 32'(e.m2r));
      chk({e.name, ".ill"},   32'(ex_illegal), 32'(e.ill));
      if (e.ca) chk({e.name, ".alu"}, 32'(ex_alu_ctrl), 32'(e.alu));
      if (e.cd) begin
        chk({e.name, ".op1"},  ex_operand1, e.op1);
        chk({e.name, ".op2"},  ex_operand2, e.op2);
        chk({e.name, ".sd"},   ex_store_data, e.sd);
        chk({e.name, ".dest"}, 32'(ex_dest), 32'(e.dest));
      end
    end
  end

  task automatic drive(bit rst, bit iv, logic [31:0] ins, bit st, bit fl,
                       bit we, logic [4:0] wa, logic [31:0] wd);
    reset = rst; in_valid = iv; instr = ins; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic tick(exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  localparam logic [31:0] ADD_T3  = 32'h012A5820;  // add $t3,$t1,$t2
  localparam logic [31:0] LW_T0   = 32'h8E28FFFC;  // lw $t0,-4($s1)
  localparam logic [31:0] ADD_Z   = 32'h00005820;  // add $t3,$zero,$zero
  localparam logic [31:0] SW_T2   = 32'hAD2A0008;  // sw $t2,8($t1)
  localparam logic [31:0] BEQ_I   = 32'h112A0003;  // beq $t1,$t2,3
  localparam logic [31:0] ADDI_I  = 32'h2128FFFF;  // addi $t0,$t1,-1
  localparam logic [31:0] BAD_OP  = 32'hFC000000;
  localparam logic [31:0] BAD_FN  = 32'h012A5807;

  logic [5:0]  fn_tab  [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0]  alu_tab [4] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
  logic [31:0] byp_exp;

  initial begin
`ifdef DECODE_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'h5;
`endif
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick(mk("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0, 1, 1));

    drive(0, 0, 0, 0, 0, 1, 9, 5);          tick(bub("wr9"));
    drive(0, 0, 0, 0, 0, 1, 10, 7);         tick(bub("wr10"));
    drive(0, 0, 0, 0, 0, 1, 17, 32'h100);   tick(bub("wr17"));

    drive(0, 1, ADD_T3, 0, 0, 0, 0, 0);
    tick(mk("add", 1, 5, 7, 7, 11, 0, 0, 1, 0, 4'b0010, 0, 1, 1));
    drive(0, 1, LW_T0, 0, 0, 0, 0, 0);
    tick(mk("lw", 1, 32'h100, 32'hFFFFFFFC, 0, 8, 1, 0, 1, 1, 4'b0010, 0, 1, 1));

    drive(0, 0, 0, 0, 0, 1, 0, 32'hDEAD);   tick(bub("wr0"));
    drive(0, 1, ADD_Z, 0, 0, 0, 0, 0);
    tick(mk("zero", 1, 0, 0, 0, 11, 0, 0, 1, 0, 4'b0010, 0, 1, 1));

    // same-cycle write to rs
    drive(0, 1, ADD_T3, 0, 0, 1, 9, 32'h55);
    tick(mk("bypass", 1, byp_exp, 7, 7, 11, 0, 0, 1, 0, 4'b0010, 0, 1, 1));
    drive(0, 1, ADD_T3, 0, 0, 0, 0, 0);
    tick(mk("after_wr", 1, 32'h55, 7, 7, 11, 0, 0, 1, 0, 4'b0010, 0, 1, 1));

    drive(0, 1, SW_T2, 0, 0, 0, 0, 0);
    tick(mk("sw", 1, 32'h55, 8, 7, 10, 0, 1, 0, 0, 4'b0010, 0, 1, 1));

    // stall two cycles with changing instr: hold sw
    drive(0, 1, BEQ_I, 1, 0, 0, 0, 0);
    #1 chk("in_ready_stall", 32'(in_ready), 0);
    tick(mk("stall1", 1, 32'h55, 8, 7, 10, 0, 1, 0, 0, 4'b0010, 0, 1, 1));
    drive(0, 1, ADDI_I, 1, 0, 0, 0, 0);
    tick(mk("stall2", 1, 32'h55, 8, 7, 10, 0, 1, 0, 0, 4'b0010, 0, 1, 1));

    drive(0, 1, BEQ_I, 0, 0, 0, 0, 0);
    #1 chk("in_ready_run", 32'(in_ready), 1);
    tick(mk("beq", 1, 32'h55, 7, 7, 10, 0, 0, 0, 0, 4'b0110, 0, 1, 1));

    drive(0, 1, ADD_T3, 1, 1, 0, 0, 0);     tick(bub("stall_flush"));

    drive(0, 1, ADDI_I, 0, 0, 0, 0, 0);
    tick(mk("addi", 1, 32'h55, 32'hFFFFFFFF, 0, 8, 0, 0, 1, 0, 4'b0010, 0, 1, 1));

    drive(0, 1, BAD_OP, 0, 0, 0, 0, 0);
    tick(mk("bad_op", 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 1, 0, 0));
    drive(0, 1, BAD_FN, 0, 0, 0, 0, 0);
    tick(mk("bad_fn", 1, 32'h55, 7, 7, 11, 0, 0, 0, 0, 4'b0000, 1, 1, 1));

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, {ADD_T3[31:6], fn_tab[i]}, 0, 0, 0, 0, 0);
      tick(mk($sformatf("funct%0d", i), 1, 32'h55, 7, 7, 11, 0, 0, 1, 0, alu_tab[i], 0, 1, 1));
    end

    // mid-run reset also blocks a concurrent write
    drive(1, 1, SW_T2, 1, 1, 1, 9, 32'h99);
    tick(mk("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0, 1, 1));
    drive(0, 1, ADD_T3, 0, 0, 0, 0, 0);
    tick(mk("post_reset", 1, 0, 0, 0, 11, 0, 0, 1, 0, 4'b0010, 0, 1, 1));

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_regfile_stage.md
Name: decode_regfile_stage

Overview:
- Parametrised successor to the single-cycle MIPS decoder/register-read logic.
- Holds an internal NUM_REGS x DATA_W register file with two read ports and one write-back port.
- Decodes the instruction into control signals, ALU control lines, operands and destination register.
- Registers everything into an ID/EX pipeline stage with valid, stall and flush control; sits between fetch (IF/ID) and the ALU.

Parameters:
- DATA_W, 32, operand and register width.
- NUM_REGS, 32, register count; power of 2, at least 2. Register 0 is hardwired zero.
- ADDR_W, $clog2(NUM_REGS), register index width; fields wider than ADDR_W are truncated to the low bits.
- IMM_SEXT, 1: sign-extend the 16-bit immediate. 0: zero-extend it.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instr holds a valid instruction.
- instr  in  32  MIPS instruction word.
- stall  in  1  hold the ID/EX register.
- flush  in  1  kill the ID/EX contents.
- in_ready  out  1  equals !stall (combinational).
- wb_en  in  1  register write enable.
- wb_addr  in  ADDR_W  write index.
- wb_data  in  DATA_W  write data.
- ex_valid  out  1  ID/EX entry valid.
- ex_operand1  out  DATA_W  value of R[rs].
- ex_operand2  out  DATA_W  R[rt], or the extended immediate when aluop=00.
- ex_store_data  out  DATA_W  R[rt], for sw.
- ex_dest  out  ADDR_W  rd for R-type, rt otherwise.
- ex_mem_r, ex_mem_w, ex_reg_w, ex_mem_to_reg  out  1 each  control bits.
- ex_alu_ctrl  out  4  ALU control lines.
- ex_illegal  out  1  unknown opcode or funct.

Behaviour:
- Reset: all registers are 0; every ex_* output is 0; ex_valid=0. Reset takes priority over stall, flush and wb_en.
- Writes: R[wb_addr] <= wb_data on a rising edge when wb_en=1 and wb_addr!=0. Writes to index 0 are ignored. Writes are independent of stall and flush.
- Reads are combinational from instr[25:21] (rs) and instr[20:16] (rt). Index 0 always reads 0.
- Decode (aluop / mem_r mem_w reg_w mem_to_reg):
  - 000000 R-type: 10 / 0 0 1 0
  - 100011 lw: 00 / 1 0 1 1
  - 101011 sw: 00 / 0 1 0 0
  - 001000 addi: 00 / 0 0 1 0
  - 000100 beq: 01 / 0 0 0 0
  - Any other opcode: all controls 0, illegal=1.
- ALU control:
  - aluop 00 gives 0010; aluop 01 gives 0110.
  - aluop 10 by funct: 100000 gives 0010, 100010 gives 0110, 100100 gives 0000, 100101 gives 0001, 101010 gives 0111.
  - Any other funct gives 0000 with illegal=1, and reg_w is forced to 0.
- Immediate: instr[15:0], extended per IMM_SEXT to DATA_W.
- ID/EX update priority per edge: reset > flush > stall > load.
  - flush: ex_valid <= 0 and control bits are cleared; data fields are don't-care.
  - stall: all ex_* hold their values.
  - load: ex_valid <= in_valid and all fields capture the decode. When in_valid=0, control bits are captured as 0.
- Latency is 1 cycle from instr to ex_*.
- flush and stall asserted together: flush wins.

Optional Feature:
- Macro DECODE_BYPASS_EN.
- Defined: when wb_en=1, wb_addr!=0 and wb_addr matches rs or rt in the same cycle, the read port returns wb_data (write-through). This value reaches ex_operand1, ex_operand2 and ex_store_data.
- Undefined: the read returns the pre-write register value. Software or the hazard logic must insert a bubble.

Decomposition:
- Package decode_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ;
  - funct constants;
  - aluop typedef (2-bit enum);
  - ALU control codes ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT;
  - the ctrl_t struct of control bits.
- Sub-module regfile_2r1w(DATA_W, NUM_REGS) holds the storage, zero-register and bypass logic. Decode and the ID/EX register stay in the top module.

Test Plan:
- Reset mid-run: after traffic, pulse reset for 1 cycle -> ex_valid=0, all ex_* =0. A following read of R[9] gives 0.
- Write R[9]=5 and R[10]=7, then load add $t3,$t1,$t2 (0x012A5820) -> next cycle ex_operand1=5, ex_operand2=7, ex_dest=11, ex_alu_ctrl=0010, ex_reg_w=1.
- Load lw $t0,-4($s1) (0x8E28FFFC) with R[17]=0x100 -> ex_operand1=0x100, ex_operand2=0xFFFFFFFC, ex_dest=8, ex_mem_r=1, ex_mem_to_reg=1.
- Write R[0]=0xDEAD, then read $zero -> 0. Same-cycle wb_addr=9 with rs=9 -> with DECODE_BYPASS_EN: wb_data; without: old value.
- Stall 2 cycles while instr changes -> ex_* unchanged. Assert stall and flush together -> ex_valid=0.
- Opcode 111111 -> ex_illegal=1, all controls 0. R-type with funct 000111 -> ex_illegal=1, ex_reg_w=0.
